regfile_2r1w: RTL
=================

Name: regfile_2r1w

Overview:
Parametrised register file, successor to the single-port RegFile. Provides one write port and two independent read ports with registered read data and a read-valid flag. Adds same-cycle write-to-read bypass, out-of-range address flagging and a sequential clear engine. Used as a general-purpose config/scratch store wherever a block needs concurrent reads.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2, <=2**ADDR)
ADDR, 4, address width in bits

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
WrEn  in  1  write request
WrAddr  in  ADDR  write address
WrData  in  WIDTH  write data
RdEnA  in  1  read request, port A
RdAddrA  in  ADDR  read address, port A
RdDataA  out  WIDTH  registered read data, port A
RdValidA  out  1  one-cycle pulse: RdDataA updated
RdEnB / RdAddrB / RdDataB / RdValidB  as port A, for port B
Clr  in  1  start sequential clear of all entries
Busy  out  1  clear engine active
AddrErr  out  1  one-cycle pulse: an enabled access had address >= DEPTH
ParErrA, ParErrB  out  1  parity error pulses (see Optional Feature)

Behaviour:
- One clock (CLK); reset asynchronous, active-high (RST). The polarity and synchronicity of the reset are fixed.
- Reset: all entries 0; RdDataA/B=0; RdValidA/B=0; Busy=0; AddrErr=0; ParErrA/B=0; FSM=IDLE; clear counter=0. Asserting RST during a clear aborts it immediately, and all entries read 0 afterwards.
- Write (IDLE only): WrEn=1 at edge with WrAddr<DEPTH -> mem[WrAddr]<=WrData at that edge. WrAddr>=DEPTH -> no write, AddrErr=1 next cycle.
- Read (IDLE only): RdEnX=1 at edge N -> RdDataX and RdValidX=1 after edge N (latency 1). RdValidX is 0 in any cycle without a read. RdDataX holds its last value when no read occurs. RdAddrX>=DEPTH -> RdDataX<=0, RdValidX=1, AddrErr=1.
- Bypass: when WrEn and RdEnX target the same valid address in the same cycle, RdDataX returns WrData (write-first). Both ports may read the same address.
- AddrErr is the OR over all three ports.
- FSM IDLE -> CLEAR when Clr=1 at an edge. Clr takes priority over a same-cycle WrEn (write dropped) and RdEn (no RdValid).
- CLEAR: Busy=1; counter writes 0 to mem[counter] each cycle, for 0..DEPTH-1. After the write of DEPTH-1, go to IDLE, Busy=0, counter=0. Total Busy cycles = DEPTH.
- In CLEAR: WrEn, RdEnA/B and Clr are ignored (no write, RdValid=0, no AddrErr).
- First access is accepted on the edge after Busy falls.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- Defined: each entry stores an extra even-parity bit computed on write; the clear engine writes parity 0. An extra input WrParFlip (1 bit) inverts the stored parity bit on a write, for test. On a read, a parity mismatch gives ParErrX=1 in the same cycle as RdValidX. A bypassed read never flags an error.
- Undefined: no parity storage, no WrParFlip port; ParErrA/B tied to 0.

Decomposition:
- Package regfile_pkg: FSM state type (IDLE, CLEAR); default WIDTH/DEPTH/ADDR constants; parity function.
- Sub-module regfile_clr_ctrl: clear FSM plus counter. Outputs Busy, clear-write-enable and clear address to the array. Storage and read ports stay in the top.

Test Plan:
1. Reset, then write 0x001D@1 and 0x00DB@3, then read A@1 and B@3 in the same cycle -> next cycle RdDataA=0x001D, RdDataB=0x00DB, both RdValid=1.
2. Same cycle: WrEn@5 with 0xBEEF, RdEnA@5, RdEnB@5 -> both read ports return 0xBEEF next cycle. A later read@5 also returns 0xBEEF.
3. Write@9 (DEPTH=8) with 0x1234 -> AddrErr pulses 1 cycle, no entry changes. Read A@9 -> RdDataA=0, RdValidA=1, AddrErr=1.
4. Fill all 8 entries with 0xFFFF, pulse Clr with WrEn@2=0x5555 in the same cycle -> Busy high exactly 8 cycles. Reads/writes during Busy are ignored (RdValid=0). Afterwards all entries read 0.
5. Start Clr, assert RST at clear cycle 3 -> Busy=0 immediately, FSM=IDLE, all entries read 0, outputs at reset values.
6. (REGFILE_PARITY_EN) Write@4 0x0007 with WrParFlip=1, read A@4 -> ParErrA=1 with RdValidA. A normal write/read of the same data -> ParErrA=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, default sizing and parity helper for the 2-read/1-write register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_ADDR  = 4;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int PAR_MAX_W = 64;

  function automatic logic par_even(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Access bus of regfile_2r1w: one write port, two read ports, clear request and status.
// WrParFlip exists only when REGFILE_PARITY_EN is defined.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR  = DEF_ADDR
);
  logic             WrEn;
  logic [ADDR-1:0]  WrAddr;
  logic [WIDTH-1:0] WrData;
`ifdef REGFILE_PARITY_EN
  logic             WrParFlip;
`endif
  logic             RdEnA;
  logic [ADDR-1:0]  RdAddrA;
  logic [WIDTH-1:0] RdDataA;
  logic             RdValidA;
  logic             RdEnB;
  logic [ADDR-1:0]  RdAddrB;
  logic [WIDTH-1:0] RdDataB;
  logic             RdValidB;
  logic             Clr;
  logic             Busy;
  logic             AddrErr;
  logic             ParErrA;
  logic             ParErrB;

  modport master (
    output WrEn, WrAddr, WrData,
`ifdef REGFILE_PARITY_EN
    output WrParFlip,
`endif
    output RdEnA, RdAddrA, RdEnB, RdAddrB, Clr,
    input  RdDataA, RdValidA, RdDataB, RdValidB, Busy, AddrErr, ParErrA, ParErrB
  );

  modport slave (
    input  WrEn, WrAddr, WrData,
`ifdef REGFILE_PARITY_EN
    input  WrParFlip,
`endif
    input  RdEnA, RdAddrA, RdEnB, RdAddrB, Clr,
    output RdDataA, RdValidA, RdDataB, RdValidB, Busy, AddrErr, ParErrA, ParErrB
  );
endinterface

// File: rtl/regfile_clr_ctrl.sv
// Sequential clear engine: walks every entry once, issuing one zero-write per cycle.
module regfile_clr_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = $clog2(DEF_DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with one write and two registered read ports, write-first bypass,
// address-range flagging and a clear engine. Optional parity via REGFILE_PARITY_EN.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR  = DEF_ADDR
) (
  input  logic     CLK,
  input  logic     RST,
  regfile_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
`ifdef REGFILE_PARITY_EN
  localparam int ENT_W = WIDTH + 1;
`else
  localparam int ENT_W = WIDTH;
`endif
  localparam logic [ADDR:0] DEPTH_W = (ADDR + 1)'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];

  logic             busy, clr_we;
  logic [IDX_W-1:0] clr_addr;

  regfile_clr_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_clr (
    .CLK      (CLK),
    .RST      (RST),
    .clr_req  (bus.Clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Accesses are taken only in IDLE and lose to a same-cycle clear request.
  logic acc_ok, wr_go, rd_go_a, rd_go_b;
  logic in_wr, in_a, in_b, wr_ok;
  logic [IDX_W-1:0] wi, ia, ib;

  assign acc_ok  = !busy && !bus.Clr;
  assign wr_go   = acc_ok && bus.WrEn;
  assign rd_go_a = acc_ok && bus.RdEnA;
  assign rd_go_b = acc_ok && bus.RdEnB;
  assign in_wr   = {1'b0, bus.WrAddr}  < DEPTH_W;
  assign in_a    = {1'b0, bus.RdAddrA} < DEPTH_W;
  assign in_b    = {1'b0, bus.RdAddrB} < DEPTH_W;
  assign wr_ok   = wr_go && in_wr;
  assign wi      = bus.WrAddr[IDX_W-1:0];
  assign ia      = bus.RdAddrA[IDX_W-1:0];
  assign ib      = bus.RdAddrB[IDX_W-1:0];

  logic [ENT_W-1:0] wr_entry;
`ifdef REGFILE_PARITY_EN
  assign wr_entry = {par_even(PAR_MAX_W'(bus.WrData)) ^ bus.WrParFlip, bus.WrData};
`else
  assign wr_entry = bus.WrData;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[wi] <= wr_entry;
    end
  end

  logic [WIDTH-1:0] rd_a_nxt, rd_b_nxt;
  logic             perr_a_nxt, perr_b_nxt;

  always_comb begin
    rd_a_nxt   = '0;
    perr_a_nxt = 1'b0;
    if (in_a) begin
      if (wr_ok && wi == ia) begin
        rd_a_nxt = bus.WrData;
      end else begin
        rd_a_nxt = mem[ia][WIDTH-1:0];
`ifdef REGFILE_PARITY_EN
        perr_a_nxt = mem[ia][WIDTH] != par_even(PAR_MAX_W'(mem[ia][WIDTH-1:0]));
`endif
      end
    end
  end

  always_comb begin
    rd_b_nxt   = '0;
    perr_b_nxt = 1'b0;
    if (in_b) begin
      if (wr_ok && wi == ib) begin
        rd_b_nxt = bus.WrData;
      end else begin
        rd_b_nxt = mem[ib][WIDTH-1:0];
`ifdef REGFILE_PARITY_EN
        perr_b_nxt = mem[ib][WIDTH] != par_even(PAR_MAX_W'(mem[ib][WIDTH-1:0]));
`endif
      end
    end
  end

  // Stage p1: registered read data, valid and error pulses
  logic [WIDTH-1:0] rd_data_a_p1, rd_data_b_p1;
  logic             vld_a_p1, vld_b_p1, addr_err_p1, par_err_a_p1, par_err_b_p1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data_a_p1 <= '0;
      rd_data_b_p1 <= '0;
      vld_a_p1     <= 1'b0;
      vld_b_p1     <= 1'b0;
      addr_err_p1  <= 1'b0;
      par_err_a_p1 <= 1'b0;
      par_err_b_p1 <= 1'b0;
    end else begin
      vld_a_p1     <= rd_go_a;
      vld_b_p1     <= rd_go_b;
      if (rd_go_a) rd_data_a_p1 <= rd_a_nxt;
      if (rd_go_b) rd_data_b_p1 <= rd_b_nxt;
      addr_err_p1  <= (wr_go && !in_wr) || (rd_go_a && !in_a) || (rd_go_b && !in_b);
      par_err_a_p1 <= rd_go_a && perr_a_nxt;
      par_err_b_p1 <= rd_go_b && perr_b_nxt;
    end
  end

  assign bus.RdDataA  = rd_data_a_p1;
  assign bus.RdDataB  = rd_data_b_p1;
  assign bus.RdValidA = vld_a_p1;
  assign bus.RdValidB = vld_b_p1;
  assign bus.AddrErr  = addr_err_p1;
  assign bus.Busy     = busy;
  assign bus.ParErrA  = par_err_a_p1;
  assign bus.ParErrB  = par_err_b_p1;

endmodule
